// File: rtl/fifo_word_scheduler_if.sv
// Purpose : bundles the FIFO read port and the two-consumer word offer port of fifo_word_scheduler.
// Latency : n/a (wiring only).
// Backpressure : consumers hold off a word simply by not acking it; the scheduler never pops while a word is held.
//
// Signals:
//   fifo_usedw  - FIFO fill level in bytes
//   fifo_rd_ena - FIFO read request, one byte per asserted cycle
//   fifo_rd_dat - FIFO read data, valid the cycle after fifo_rd_ena
//   req / ack   - per-consumer word request (level) and accept (pulse)
//   gnt         - one-hot grant or 0
//   word_vld    - assembled word is held and offered
//   word_dat    - assembled word {first byte, second byte}
// Modports: master = the scheduler, slave = FIFO plus consumers.
interface fifo_word_scheduler_if #(
    parameter int USEDW_W = 11
);
    logic [USEDW_W-1:0] fifo_usedw;
    logic               fifo_rd_ena;
    logic [7:0]         fifo_rd_dat;
    logic [1:0]         req;
    logic [1:0]         ack;
    logic [1:0]         gnt;
    logic               word_vld;
    logic [15:0]        word_dat;

    modport master (
        input  fifo_usedw,
        input  fifo_rd_dat,
        input  req,
        input  ack,
        output fifo_rd_ena,
        output gnt,
        output word_vld,
        output word_dat
    );

    modport slave (
        output fifo_usedw,
        output fifo_rd_dat,
        output req,
        output ack,
        input  fifo_rd_ena,
        input  gnt,
        input  word_vld,
        input  word_dat
    );
endinterface

// File: rtl/fifo_word_scheduler.sv
// Purpose : paced reader of byte pairs from the command/pixel FIFO, assembled into 16-bit words and offered to two consumers under round-robin.
// Latency : 3 cycles from leaving IDLE to word_vld; minimum word period PACE+5 cycles.
// Backpressure : an offered word is held (no further FIFO pops) until the granted consumer acks it.
//
// Ports:
//   clk   - system clock, all logic on posedge
//   reset - asynchronous active-low reset
//   bus   - fifo_word_scheduler_if.master (FIFO read port + word offer/grant port)
module fifo_word_scheduler #(
    parameter int PACE    = 200000,
    parameter int PACE_W  = 27,
    parameter int USEDW_W = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    fifo_word_scheduler_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_HI  = 3'd1,
        RD_LO  = 3'd2,
        CAP_LO = 3'd3,
        OFFER  = 3'd4
    } state_t;

    localparam logic [PACE_W-1:0]  PACE_C   = PACE_W'(PACE);
    localparam logic [USEDW_W-1:0] MIN_FILL = USEDW_W'(2);

    state_t              state_q,    state_d;
    logic [PACE_W-1:0]   pace_cnt_q, pace_cnt_d;
    logic                rd_ena_q,   rd_ena_d;
    logic [1:0]          gnt_q,      gnt_d;
    logic                vld_q,      vld_d;
    logic [15:0]         dat_q,      dat_d;
    // prio_q = index of the requester that wins a tie
    logic                prio_q,     prio_d;

    logic [1:0]          rr_pick;
    logic                xfer_done;
    logic                fetch_go;

    // Round-robin choice from the live request vector.
    always_comb begin
        rr_pick = 2'b00;
        case (bus.req)
            2'b01:   rr_pick = 2'b01;
            2'b10:   rr_pick = 2'b10;
            2'b11:   rr_pick = prio_q ? 2'b10 : 2'b01;
            default: rr_pick = 2'b00;
        endcase
    end

    // Only an ack on the granted bit counts; with gnt=0 every ack is ignored.
    assign xfer_done = (state_q == OFFER) && ((bus.ack & gnt_q) != 2'b00);

    // Both bytes must already be in the FIFO so a lone byte is never popped.
    assign fetch_go = (pace_cnt_q >= PACE_C) && (bus.fifo_usedw >= MIN_FILL) && (bus.req != 2'b00);

    always_comb begin
        state_d    = state_q;
        pace_cnt_d = pace_cnt_q;
        gnt_d      = gnt_q;
        vld_d      = vld_q;
        dat_d      = dat_q;
        prio_d     = prio_q;

        case (state_q)
            IDLE: begin
                if (fetch_go) begin
                    state_d    = RD_HI;
                    pace_cnt_d = '0;
                end else if (pace_cnt_q < PACE_C) begin
                    // Saturate instead of wrapping during long stalls.
                    pace_cnt_d = pace_cnt_q + PACE_W'(1);
                end
            end
            RD_HI: begin
                state_d = RD_LO;
            end
            RD_LO: begin
                // Data returned for the RD_HI pop is the first (high) byte.
                dat_d[15:8] = bus.fifo_rd_dat;
                state_d     = CAP_LO;
            end
            CAP_LO: begin
                dat_d[7:0] = bus.fifo_rd_dat;
                state_d    = OFFER;
                vld_d      = 1'b1;
                // Load the grant on entry so a waiting consumer can ack in the first OFFER cycle.
                gnt_d      = rr_pick;
            end
            OFFER: begin
                if (xfer_done) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    gnt_d   = 2'b00;
                    // Hand the tie-break to whichever requester was not just served.
                    prio_d  = gnt_q[0];
                end else if (gnt_q == 2'b00) begin
                    // Grant stays open until some requester shows up; once set it is held.
                    gnt_d = rr_pick;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                gnt_d   = 2'b00;
            end
        endcase

        // Registered read enable: high exactly while in RD_HI and RD_LO.
        rd_ena_d = (state_d == RD_HI) || (state_d == RD_LO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pace_cnt_q <= '0;
            rd_ena_q   <= 1'b0;
            gnt_q      <= 2'b00;
            vld_q      <= 1'b0;
            dat_q      <= 16'h0000;
            prio_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pace_cnt_q <= pace_cnt_d;
            rd_ena_q   <= rd_ena_d;
            gnt_q      <= gnt_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
            prio_q     <= prio_d;
        end
    end

    assign bus.fifo_rd_ena = rd_ena_q;
    assign bus.gnt         = gnt_q;
    assign bus.word_vld    = vld_q;
    assign bus.word_dat    = dat_q;

endmodule

// File: tb/tb_fifo_word_scheduler.sv
// Purpose : directed bench for fifo_word_scheduler with a byte-FIFO model and a word/grant scoreboard.
// Latency : checks fetch timing, offer latency and pacing period for PACE=4.
// Backpressure : consumers ack from the bench; some words are held to exercise late grants.
module tb_fifo_word_scheduler;

    localparam int PACE    = 4;
    localparam int PACE_W  = 27;
    localparam int USEDW_W = 11;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_word_scheduler_if #(.USEDW_W(USEDW_W)) bus ();

    fifo_word_scheduler #(
        .PACE    (PACE),
        .PACE_W  (PACE_W),
        .USEDW_W (USEDW_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  fifo_q[$];
    logic [15:0] exp_word_q[$];
    logic [1:0]  exp_gnt_q[$];

    // Byte FIFO model, show-ahead off: data appears the cycle after the read.
    always @(posedge clk) begin
        if (bus.fifo_rd_ena === 1'b1) begin
            if (fifo_q.size() > 0) bus.fifo_rd_dat <= fifo_q.pop_front();
            else                   bus.fifo_rd_dat <= 8'h00;
        end
    end

    // Spacing between consecutive rising edges of fifo_rd_ena, in clock cycles.
    int   cyc       = 0;
    int   last_rise = -1;
    int   rise_gap  = 0;
    logic rd_prev   = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_prev <= bus.fifo_rd_ena;
        if (bus.fifo_rd_ena === 1'b1 && rd_prev == 1'b0) begin
            if (last_rise >= 0) rise_gap <= cyc - last_rise;
            last_rise <= cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] hi, input logic [7:0] lo, input logic [1:0] g);
        fifo_q.push_back(hi);
        fifo_q.push_back(lo);
        exp_word_q.push_back({hi, lo});
        exp_gnt_q.push_back(g);
    endtask

    // Wait for an offered and granted word, score it, ack it, and confirm the offer drops.
    task automatic serve(input string tag);
        int          n;
        logic [15:0] ew;
        logic [1:0]  eg;
        n = 0;
        while (!(bus.word_vld === 1'b1 && bus.gnt !== 2'b00) && n < 100) begin
            @(negedge clk);
            n++;
        end
        ew = exp_word_q.pop_front();
        eg = exp_gnt_q.pop_front();
        if (n >= 100) begin
            check({tag, "_offer_timeout"}, 32'(bus.word_vld), 32'd1);
        end else begin
            check({tag, "_word"}, 32'(bus.word_dat), 32'(ew));
            check({tag, "_gnt"},  32'(bus.gnt),      32'(eg));
            bus.ack = bus.gnt;
            @(negedge clk);
            bus.ack = 2'b00;
            check({tag, "_vld_drop"}, 32'(bus.word_vld), 32'd0);
            check({tag, "_gnt_drop"}, 32'(bus.gnt),      32'd0);
        end
    endtask

    initial begin
        int n;
        int rd_seen;

        // Reset held with live requests and a full FIFO: all outputs stay 0.
        reset          = 1'b0;
        bus.req        = 2'b11;
        bus.ack        = 2'b00;
        bus.fifo_usedw = 11'd10;
        repeat (3) @(negedge clk);
        check("rst_rd_ena",   32'(bus.fifo_rd_ena), 32'd0);
        check("rst_gnt",      32'(bus.gnt),         32'd0);
        check("rst_word_vld", 32'(bus.word_vld),    32'd0);
        check("rst_word_dat", 32'(bus.word_dat),    32'd0);

        // First word after release: reads on cycles 5-6, offer on cycle 8, high byte first.
        push_word(8'hA5, 8'h3C, 2'b01);
        bus.req = 2'b01;
        reset   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("first_rd_ena_c%0d", i), 32'(bus.fifo_rd_ena), 32'((i == 5) || (i == 6)));
            check($sformatf("first_vld_c%0d", i),    32'(bus.word_vld),    32'(i == 8));
        end
        serve("byte_order");

        // Requester 1 alone wins every word.
        push_word(8'h11, 8'h22, 2'b10);
        push_word(8'h33, 8'h44, 2'b10);
        bus.req = 2'b10;
        serve("only_req1_a");
        serve("only_req1_b");

        // Both requesting: strict alternation, starting with requester 0.
        push_word(8'h55, 8'h66, 2'b01);
        push_word(8'h77, 8'h88, 2'b10);
        push_word(8'h99, 8'hAA, 2'b01);
        push_word(8'hBB, 8'hCC, 2'b10);
        bus.req = 2'b11;
        serve("rr_0");
        serve("rr_1");
        serve("rr_2");
        serve("rr_3");
        check("pace_period", 32'(rise_gap), 32'(PACE + 5));

        // One byte in the FIFO never starts a fetch.
        bus.fifo_usedw = 11'd1;
        bus.req        = 2'b10;
        rd_seen        = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.fifo_rd_ena === 1'b1) rd_seen++;
        end
        check("stall_no_rd", 32'(rd_seen), 32'd0);

        // Release the stall, then drop req during the fetch: word waits ungranted.
        push_word(8'h5A, 8'hC3, 2'b10);
        bus.fifo_usedw = 11'd2;
        n = 0;
        while (bus.fifo_rd_ena !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("stall_release_rd", 32'(bus.fifo_rd_ena), 32'd1);
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        check("late_vld",      32'(bus.word_vld), 32'd1);
        check("late_gnt_zero", 32'(bus.gnt),      32'd0);
        check("late_dat",      32'(bus.word_dat), 32'h5AC3);
        @(negedge clk);
        check("late_gnt_still_zero", 32'(bus.gnt), 32'd0);
        // Request and ack together while ungranted: ack ignored, grant loads.
        bus.req = 2'b10;
        bus.ack = 2'b10;
        @(negedge clk);
        check("late_gnt_loaded", 32'(bus.gnt),      32'h2);
        check("late_ack_ignored", 32'(bus.word_vld), 32'd1);
        // Ack on the other bit is ignored; grant is held after req drops.
        bus.ack = 2'b01;
        bus.req = 2'b00;
        @(negedge clk);
        check("wrong_ack_vld", 32'(bus.word_vld), 32'd1);
        check("held_gnt",      32'(bus.gnt),      32'h2);
        bus.ack = 2'b00;
        serve("late_grant");

        // Asynchronous reset while a word is offered: outputs drop at once, word is lost.
        fifo_q.push_back(8'hE7);
        fifo_q.push_back(8'h18);
        bus.req        = 2'b01;
        bus.fifo_usedw = 11'd10;
        n = 0;
        while (bus.word_vld !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("arst_offer_reached", 32'(bus.word_vld), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_vld",      32'(bus.word_vld),    32'd0);
        check("arst_gnt",      32'(bus.gnt),         32'd0);
        check("arst_rd_ena",   32'(bus.fifo_rd_ena), 32'd0);
        check("arst_word_dat", 32'(bus.word_dat),    32'd0);
        @(negedge clk);
        push_word(8'h96, 8'h69, 2'b01);
        reset = 1'b1;
        // A fresh pacing wait precedes the next fetch.
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("post_arst_rd_c%0d", i), 32'(bus.fifo_rd_ena), 32'(i == 5));
        end
        serve("post_arst");
        bus.req = 2'b00;

        check("scoreboard_empty", 32'(exp_word_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
